// File: rtl/jk_cmd_sequencer.sv
// Command sequencer driving a downstream JK flip-flop: queued {op,count} commands
// are replayed as registered J/K pulses while a local model checks the fed-back Q.
module jk_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [3:0] in_count,
  output logic       J,
  output logic       K,
  input  logic       q_fb,
  output logic       exp_q,
  output logic       mismatch,
  output logic       busy,
  output logic [7:0] ops_done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  // Handshake: a command transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready depends only on registered occupancy, never on in_valid.

  logic [5:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic [5:0]  head;
  logic [3:0]  head_cnt;

  state_t      state;
  logic [1:0]  cur_op;
  logic [3:0]  remaining;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign busy     = !empty || (state == S_ISSUE);
  assign push     = in_valid && !full && !rst;
  // Pop on entry to ISSUE, or back-to-back on the last cycle of the current command.
  assign pop      = !empty && ((state == S_IDLE) || (remaining == 4'd1));
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_cnt = (head[3:0] == 4'd0) ? 4'd1 : head[3:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_op, in_count};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= S_IDLE;
      cur_op    <= 2'b00;
      remaining <= 4'd0;
      J         <= 1'b0;
      K         <= 1'b0;
      exp_q     <= 1'b0;
      mismatch  <= 1'b0;
      ops_done  <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end

      // The op code is the {J,K} pattern itself: hold 00, reset 01, set 10, toggle 11.
      if (state == S_ISSUE) begin
        {J, K} <= cur_op;
      end else begin
        {J, K} <= 2'b00;
      end

      // Model of the downstream flip-flop, driven by the same registered J/K it sees.
      case ({J, K})
        2'b01:   exp_q <= 1'b0;
        2'b10:   exp_q <= 1'b1;
        2'b11:   exp_q <= ~exp_q;
        default: exp_q <= exp_q;
      endcase

      if (q_fb != exp_q) begin
        mismatch <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!empty) begin
            cur_op    <= head[5:4];
            remaining <= head_cnt;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (remaining == 4'd1) begin
            ops_done <= ops_done + 8'd1;
            if (!empty) begin
              cur_op    <= head[5:4];
              remaining <= head_cnt;
            end else begin
              remaining <= 4'd0;
              state     <= S_IDLE;
            end
          end else begin
            remaining <= remaining - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: per-edge J/K schedule built from accepted commands,
// with a behavioural JK flip-flop closing the q_fb loop.
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_op = 2'b00;
  logic [3:0] in_count = 4'd0;
  logic       in_ready;
  logic       J;
  logic       K;
  logic       q_fb;
  logic       dut_exp_q;
  logic       mismatch;
  logic       busy;
  logic [7:0] ops_done;

  logic q_ff = 1'b0;
  logic force_zero = 1'b0;
  logic mis_model = 1'b0;
  int   cyc = 0;

  logic [33:0] exp_q[$];
  int          done_q[$];
  int          last_edge = 0;
  int          last_acc = 0;
  logic [7:0]  ops_exp = 8'd0;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [33:0] mon_h;
  logic [1:0]  mon_want;

  always #5 clk = ~clk;

  assign q_fb = force_zero ? 1'b0 : q_ff;

  jk_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_count (in_count),
    .J        (J),
    .K        (K),
    .q_fb     (q_fb),
    .exp_q    (dut_exp_q),
    .mismatch (mismatch),
    .busy     (busy),
    .ops_done (ops_done)
  );

  // Downstream JK flip-flop and the reference sticky-mismatch flag.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      q_ff      <= 1'b0;
      mis_model <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
      if (q_fb !== q_ff) mis_model <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  function automatic logic [1:0] jk_of(input logic [1:0] op);
    case (op)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Commands execute in order, each taking max(count,1) cycles; the first starts two
  // edges after its accept, or straight after the previous command, whichever is later.
  task automatic model_accept(input logic [1:0] op, input logic [3:0] cnt, input int a);
    int n;
    int first;
    n = (cnt == 4'd0) ? 1 : int'(cnt);
    first = (a + 2 > last_edge + 1) ? a + 2 : last_edge + 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({32'(first + i), jk_of(op)});
    end
    last_edge = first + n - 1;
    done_q.push_back(last_edge);
    last_acc = a;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_want = 2'b00;
      if (exp_q.size() != 0 && exp_q[0][33:2] == 32'(cyc)) begin
        mon_h = exp_q.pop_front();
        mon_want = mon_h[1:0];
      end
      chk("jk", {30'd0, J, K}, {30'd0, mon_want});
      while (done_q.size() != 0 && done_q[0] <= cyc) begin
        void'(done_q.pop_front());
        ops_exp = ops_exp + 8'd1;
      end
      chk("ops_done", {24'd0, ops_done}, {24'd0, ops_exp});
      chk("busy", {31'd0, busy}, {31'd0, done_q.size() != 0});
      chk("exp_q", {31'd0, dut_exp_q}, {31'd0, q_ff});
      chk("mismatch", {31'd0, mismatch}, {31'd0, mis_model});
    end
  end

  // Tasks start and end one time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    ops_exp = 8'd0;
    last_edge = cyc;
    chk("rst_jk", {30'd0, J, K}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ops", {24'd0, ops_done}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_expq", {31'd0, dut_exp_q}, 32'd0);
    chk("rst_mis", {31'd0, mismatch}, 32'd0);
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] cnt);
    logic rdy;
    int   a;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_count = cnt;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      rdy = in_ready;
      a = cyc + 1;
      @(posedge clk);
      #1;
      if (rdy) begin
        model_accept(op, cnt, a);
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("push_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (exp_q.size() == 0 && done_q.size() == 0 && cyc > last_edge + 1) ok = 1'b1;
      else idle(1);
    end
    chk("drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int a;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;

    // Single set-Q.
    push(2'd2, 4'd1);
    drain();
    chk("set1_expq", {31'd0, dut_exp_q}, 32'd1);
    chk("set1_qfb", {31'd0, q_fb}, 32'd1);
    chk("set1_ops", {24'd0, ops_done}, 32'd1);
    chk("set1_mis", {31'd0, mismatch}, 32'd0);

    // Toggle x5 from Q=0 ends at Q=1.
    do_reset();
    push(2'd3, 4'd5);
    drain();
    chk("tog5_expq", {31'd0, dut_exp_q}, 32'd1);

    // Count 0 behaves as 1.
    push(2'd1, 4'd0);
    drain();
    chk("rq0_expq", {31'd0, dut_exp_q}, 32'd0);

    // Even toggle count leaves Q unchanged.
    push(2'd3, 4'd4);
    drain();
    chk("tog4_expq", {31'd0, dut_exp_q}, 32'd0);

    // Fill the queue behind a long command.
    do_reset();
    push(2'd3, 4'd15);
    idle(2);
    push(2'd2, 4'd2);
    push(2'd0, 4'd3);
    push(2'd3, 4'd1);
    push(2'd1, 4'd2);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    push(2'd3, 4'd3);
    drain();
    chk("fill_ops", {24'd0, ops_done}, 32'd6);

    // Sticky mismatch.
    do_reset();
    push(2'd2, 4'd1);
    drain();
    force_zero = 1'b1;
    idle(1);
    force_zero = 1'b0;
    chk("mis_set", {31'd0, mismatch}, 32'd1);
    idle(5);
    chk("mis_sticky", {31'd0, mismatch}, 32'd1);
    do_reset();

    // Reset in the 3rd cycle of toggle x8 with two commands queued.
    push(2'd3, 4'd8);
    a = last_acc;
    push(2'd2, 4'd2);
    push(2'd1, 4'd3);
    while (cyc < a + 4) idle(1);
    do_reset();
    idle(20);
    chk("abort_ops", {24'd0, ops_done}, 32'd0);

    // Random commands with random gaps, one mid-run reset.
    for (int k = 0; k < 40; k++) begin
      push(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 3) + 1 - 1);
      if (k == 20) do_reset();
    end
    drain();
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("final_ready", {31'd0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, command queue depth; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: command offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: command queue can accept.
REQ-006 The block SHALL have port in_op, input, 2 bits: operation code 00 hold, 01 reset-Q, 10 set-Q, 11 toggle.
REQ-007 The block SHALL have port in_count, input, 4 bits: number of consecutive cycles to apply the op; 0 is treated as 1.
REQ-008 The block SHALL have port J, output, 1 bit: registered J drive to the downstream JK flip-flop.
REQ-009 The block SHALL have port K, output, 1 bit: registered K drive to the downstream JK flip-flop.
REQ-010 The block SHALL have port q_fb, input, 1 bit: Q fed back from the downstream flip-flop.
REQ-011 The block SHALL have port exp_q, output, 1 bit: modelled expected Q.
REQ-012 The block SHALL have port mismatch, output, 1 bit: sticky flag, set when q_fb differs from exp_q.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the queue is non-empty or the FSM is in ISSUE.
REQ-014 The block SHALL have port ops_done, output, 8 bits: count of completed commands; wraps 255 to 0.

Function
REQ-015 A command SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; {in_op, in_count} is written to the FIFO tail.
REQ-016 in_ready SHALL equal NOT full; a push is refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-017 A push and a pop in the same cycle on a non-full, non-empty FIFO SHALL both take effect, leaving the occupancy unchanged.
REQ-018 An entry pushed into an empty FIFO SHALL NOT be poppable until the following cycle.
REQ-019 The FSM SHALL have two states, IDLE and ISSUE.
REQ-020 IDLE with the FIFO non-empty SHALL pop the head, load cur_op, load remaining=max(count,1), and go to ISSUE; otherwise it remains in IDLE.
REQ-021 In ISSUE the {J,K} registers SHALL hold the mapping of cur_op: hold=00, reset-Q=01, set-Q=10, toggle=11.
REQ-022 Each ISSUE cycle SHALL decrement remaining.
REQ-023 When remaining=1 in ISSUE, ops_done SHALL increment; if the FIFO is non-empty, the next entry is popped back-to-back (no gap cycle) and the FSM stays in ISSUE; otherwise the FSM goes to IDLE and J,K return to 00.
REQ-024 J and K SHALL be 00 whenever the FSM is in IDLE.
REQ-025 Latency: for a command accepted on edge N into an empty, idle block, J,K SHALL be valid after edge N+2; the flip-flop reflects the first application after edge N+3.
REQ-026 exp_q SHALL update each edge from the current registered J,K: 00 gives exp_q, 01 gives 0, 10 gives 1, 11 gives NOT exp_q. It thus tracks the flip-flop's Q edge-for-edge.
REQ-027 mismatch SHALL be set on any edge where rst=0 and q_fb differs from exp_q; it stays set until rst.
REQ-028 Toggle with count n SHALL leave exp_q inverted if n is odd and unchanged if n is even.

Reset
REQ-029 With rst=1 on an edge, the block SHALL set: FIFO empty, FSM to IDLE, J=0, K=0, exp_q=0, mismatch=0, ops_done=0, remaining=0, in_ready=1 and busy=0 after that edge.
REQ-030 Reset asserted mid-ISSUE SHALL discard the current and all queued commands; no partial command counts in ops_done.
REQ-031 A push presented while rst=1 SHALL be ignored.

Verification
REQ-032 Scenario: after reset, push set-Q with count 1 -> J,K=10 for exactly one cycle; exp_q=1, q_fb=1, ops_done=1, mismatch=0.
REQ-033 Scenario: push toggle with count 5 from Q=0 -> J,K=11 for 5 consecutive cycles; final exp_q=1; then J,K=00.
REQ-034 Scenario: push 5 commands back-to-back with FIFO_DEPTH=4 and the FSM stalled behind a count-15 command -> in_ready=0 after the 4th accept; the 5th is held until a pop; all 5 execute in order with no gap cycles.
REQ-035 Scenario: in_count=0 with op reset-Q -> exactly one cycle of J,K=01.
REQ-036 Scenario: force q_fb=0 while exp_q=1 -> mismatch=1 on the next edge and it stays 1 until rst.
REQ-037 Scenario: assert rst during the 3rd cycle of a toggle with count 8 and 2 entries queued -> after the edge, J,K=00, busy=0, ops_done=0, and no further J,K activity.
